// File: rtl/maxpool_pkg.sv
// ============================================================================
// Module   : maxpool_pkg
// Purpose  : Shared defaults and sample type for the max-pooling output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package maxpool_pkg;

    localparam int T_DEFAULT = 16;
    localparam int P_DEFAULT = 2;

    typedef logic signed [T_DEFAULT-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/max_cmp.sv
// ============================================================================
// Module   : max_cmp
// Purpose  : Two's-complement maximum of two samples; ties return input a.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_cmp
    import maxpool_pkg::*;
#(
    parameter int T = T_DEFAULT
) (
    input  logic signed [T-1:0] a,
    input  logic signed [T-1:0] b,
    output logic signed [T-1:0] y
);

    // Strict compare so an equal b never displaces the value held in a
    assign y = (b > a) ? b : a;

endmodule

`default_nettype wire

// File: rtl/maxpool_out_16_2.sv
// ============================================================================
// Module   : maxpool_out_16_2
// Purpose  : Streaming non-overlapping max-pool over windows of P samples with
//            valid/ready on both sides. Define MAXPOOL_RELU_EN to clamp
//            negative window maxima to zero at the output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_out_16_2
    import maxpool_pkg::*;
#(
    parameter int T = T_DEFAULT,
    parameter int P = P_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);

    localparam int             C_CNT_W    = (P > 2) ? $clog2(P) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(P - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic signed [T-1:0] r_acc;
    logic signed [T-1:0] w_max;
    logic signed [T-1:0] w_pool;
    logic                w_in_fire;
    logic                w_last;

    // Stall only while a result is waiting on a blocked consumer
    assign s_ready_x = ~(m_valid_y & ~m_ready_y);
    assign w_in_fire = s_valid_x & s_ready_x;
    assign w_last    = (r_cnt == C_CNT_LAST);

    max_cmp #(
        .T (T)
    ) u_max_cmp (
        .a (r_acc),
        .b (s_data_in_x),
        .y (w_max)
    );

    always_comb begin
        w_pool = w_max;
`ifdef MAXPOOL_RELU_EN
        if (w_max[T-1]) begin
            w_pool = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            m_data_out_y <= '0;
            m_valid_y    <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_last) begin
                    r_cnt        <= '0;
                    m_data_out_y <= w_pool;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    r_acc <= (r_cnt == '0) ? s_data_in_x : w_max;
                end
            end
            // A completing window overrides a concurrent drain of the old result
            if (w_in_fire && w_last) begin
                m_valid_y <= 1'b1;
            end else if (m_ready_y) begin
                m_valid_y <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_out_16_2.sv
// ============================================================================
// Module   : tb_maxpool_out_16_2
// Purpose  : Directed table vectors, handshake corner cases and a randomized
//            scoreboard run for maxpool_out_16_2 (P=2 and P=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_out_16_2;
    import maxpool_pkg::*;

    typedef struct {
        sample_t a;
        sample_t b;
        sample_t exp;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset;
    sample_t s_data, m_data, s_data4, m_data4;
    logic    s_valid, s_ready, m_valid, m_ready;
    logic    s_valid4, s_ready4, m_valid4, m_ready4;

    int checks = 0;
    int errors = 0;

    maxpool_out_16_2 #(.T(16), .P(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data),
        .s_valid_x    (s_valid),
        .s_ready_x    (s_ready),
        .m_data_out_y (m_data),
        .m_valid_y    (m_valid),
        .m_ready_y    (m_ready)
    );

    maxpool_out_16_2 #(.T(16), .P(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data4),
        .s_valid_x    (s_valid4),
        .s_ready_x    (s_ready4),
        .m_data_out_y (m_data4),
        .m_valid_y    (m_valid4),
        .m_ready_y    (m_ready4)
    );

    always #5 clk = ~clk;

    function automatic sample_t relu(input sample_t v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? sample_t'(0) : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one sample on the P=2 instance; returns 1ns after the accepting edge
    task automatic push(input sample_t v);
        int waited;
        waited = 0;
        s_valid = 1'b1;
        s_data  = v;
        @(negedge clk);
        while (!s_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: got s_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t    vecs[8];
    sample_t w4[8];
    sample_t e4[2];

    initial begin
        vecs[0] = '{a: 16'sd3,      b: -16'sd5,     exp: 16'sd3};
        vecs[1] = '{a: -16'sd7,     b: -16'sd2,     exp: relu(-16'sd2)};
        vecs[2] = '{a: -16'sd7,     b: -16'sd2,     exp: relu(-16'sd2)};
        vecs[3] = '{a: 16'sd4,      b: 16'sd4,      exp: 16'sd4};
        vecs[4] = '{a: 16'sh8000,   b: 16'sh7FFF,   exp: 16'sh7FFF};
        vecs[5] = '{a: 16'sd100,    b: -16'sd100,   exp: 16'sd100};
        vecs[6] = '{a: -16'sd1,     b: 16'sh8000,   exp: relu(-16'sd1)};
        vecs[7] = '{a: 16'sh7FFE,   b: 16'sh7FFF,   exp: 16'sh7FFF};

        w4[0] = 16'sh8000; w4[1] = 16'sh7FFF; w4[2] = 16'sh0000; w4[3] = 16'shFFFF;
        w4[4] = -16'sd5;   w4[5] = -16'sd3;   w4[6] = -16'sd8;   w4[7] = -16'sd4;
        e4[0] = 16'sh7FFF;
        e4[1] = relu(-16'sd3);

        reset = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        s_valid4 = 1'b0; s_data4 = '0; m_ready4 = 1'b1;
        idle(3);
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_data", m_data, 32'd0);
        chk("reset_ready", {31'd0, s_ready}, 32'd1);
        reset = 1'b1;
        idle(1);

        // Table: each record is one P=2 window streamed back to back
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].a);
            chk($sformatf("vec%0d_mid_valid", i), {31'd0, m_valid}, 32'd0);
            push(vecs[i].b);
            chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), m_data, vecs[i].exp);
        end
        idle(2);

        // Backpressure: result held, input stalled, stalled sample not lost
        m_ready = 1'b0;
        push(16'sd7);
        push(16'sd9);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
        fork
            push(16'sd6);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold_data", m_data, 32'd9);
                    chk("bp_hold_ready", {31'd0, s_ready}, 32'd0);
                end
                m_ready = 1'b1;
            end
        join
        chk("bp_drain_valid", {31'd0, m_valid}, 32'd0);
        push(-16'sd4);
        chk("bp_next_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_next_data", m_data, 32'd6);
        idle(2);

        // Mid-window reset discards the partial window
        push(16'sd10);
        #2 reset = 1'b0;
        #2;
        chk("async_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("async_rst_data", m_data, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        push(16'sd1);
        chk("rst_partial_valid", {31'd0, m_valid}, 32'd0);
        push(16'sd2);
        chk("rst_out_valid", {31'd0, m_valid}, 32'd1);
        chk("rst_out_data", m_data, 32'd2);
        idle(2);

        // P=4 extreme values
        for (int i = 0; i < 8; i++) begin
            s_valid4 = 1'b1;
            s_data4  = w4[i];
            @(posedge clk);
            #1;
            if ((i % 4) == 3) begin
                chk($sformatf("p4_valid%0d", i), {31'd0, m_valid4}, 32'd1);
                chk($sformatf("p4_data%0d", i), m_data4, e4[i / 4]);
            end else begin
                chk($sformatf("p4_idle%0d", i), {31'd0, m_valid4}, 32'd0);
            end
        end
        s_valid4 = 1'b0;
        idle(2);

        // Random valid/ready against a reference window model
        begin
            int      sent, got, cyc, mcnt;
            sample_t macc;
            sample_t q[$];
            sent = 0; got = 0; cyc = 0; mcnt = 0; macc = '0;
            while ((sent < 2340 || q.size() > 0) && cyc < 40000) begin
                @(posedge clk);
                #1;
                s_valid = (sent < 2340) && ($urandom_range(0, 1) == 1);
                s_data  = 16'($urandom);
                m_ready = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_spurious: got output %0h expected none", m_data);
                    end else begin
                        chk("rand_data", m_data, q.pop_front());
                    end
                    got++;
                end
                if (s_valid && s_ready) begin
                    macc = (mcnt == 0 || s_data > macc) ? s_data : macc;
                    mcnt++;
                    if (mcnt == 2) begin
                        q.push_back(relu(macc));
                        mcnt = 0;
                    end
                    sent++;
                end
                cyc++;
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
            chk("rand_timeout", {31'd0, cyc < 40000}, 32'd1);
            chk("rand_outputs", got, 32'd1170);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
